// File: rtl/reg_readback_if.sv
// rtl/reg_readback_if.sv - register readback bus: bank taps in, debug word stream out
// Optional Parity signal present only when READBACK_PARITY_EN is defined.
interface reg_readback_if #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
);
    logic                   Start;
    logic [WIDTH*NREGS-1:0] Regs;
    logic                   Ready;
    logic [2:0]             Sel;
    logic [WIDTH-1:0]       Data;
    logic                   Valid;
    logic                   Busy;
    logic                   Done;
`ifdef READBACK_PARITY_EN
    logic                   Parity;

    modport master (
        input  Start, Regs, Ready,
        output Sel, Data, Valid, Busy, Done, Parity
    );

    modport slave (
        output Start, Regs, Ready,
        input  Sel, Data, Valid, Busy, Done, Parity
    );
`else
    modport master (
        input  Start, Regs, Ready,
        output Sel, Data, Valid, Busy, Done
    );

    modport slave (
        output Start, Regs, Ready,
        input  Sel, Data, Valid, Busy, Done
    );
`endif
endinterface

// File: rtl/reg_readback.sv
// rtl/reg_readback.sv - sequential register bank dump onto a valid/ready debug stream
// Optional feature macro: READBACK_PARITY_EN adds a registered even-parity bit of Data.
// Resetn is active-high and synchronous; it aborts any dump without a Done pulse.
module reg_readback #(
    parameter int WIDTH = 16,
    parameter int NREGS = 8
) (
    input  logic           Clock,
    input  logic           Resetn,
    reg_readback_if.master bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_SEND = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [2:0] LAST_SEL = 3'(NREGS - 1);

    logic [1:0]       state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] reg_word;
`ifdef READBACK_PARITY_EN
    logic             parity_q, parity_d;
`endif

    // Select the tapped register addressed by the current index.
    always_comb begin
        reg_word = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel_q == 3'(i)) begin
                reg_word = bus.Regs[i*WIDTH +: WIDTH];
            end
        end
    end

    // Dump sequencer: capture one word per LOAD, hold it in SEND until accepted.
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = valid_q;
`ifdef READBACK_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    sel_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // Snapshot taken here only; later bank updates cannot touch a pending word.
                data_d  = reg_word;
                valid_d = 1'b1;
`ifdef READBACK_PARITY_EN
                parity_d = ^reg_word;
`endif
                state_d = S_SEND;
            end
            S_SEND: begin
                if (bus.Ready) begin
                    valid_d = 1'b0;
                    if (sel_q == LAST_SEL) begin
                        // Index is left at the last register; the next Start clears it.
                        state_d = S_DONE;
                    end else begin
                        sel_d   = sel_q + 3'd1;
                        state_d = S_LOAD;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-high reset.
    always_ff @(posedge Clock) begin
        if (Resetn) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
`ifdef READBACK_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
`ifdef READBACK_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign bus.Sel   = sel_q;
    assign bus.Data  = data_q;
    assign bus.Valid = valid_q;
    assign bus.Busy  = (state_q != S_IDLE);
    assign bus.Done  = (state_q == S_DONE);
`ifdef READBACK_PARITY_EN
    assign bus.Parity = parity_q;
`endif

endmodule

// File: tb/tb_reg_readback.sv
// tb/tb_reg_readback.sv - randomized bench for reg_readback with a cycle-stamp reference model
module tb_reg_readback;

    localparam int WIDTH = 16;
    localparam int NREGS = 8;

    logic Clock;
    logic Resetn;

    reg_readback_if #(.WIDTH(WIDTH), .NREGS(NREGS)) bus ();

    reg_readback #(.WIDTH(WIDTH), .NREGS(NREGS)) dut (
        .Clock  (Clock),
        .Resetn (Resetn),
        .bus    (bus)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    int checks = 0;
    int errors = 0;
    int hs_cnt = 0;
    int done_cnt = 0;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference model: a dump is a list of NREGS words; each word is captured one
    // edge after the dump is started or the previous word is handshaken, and Done
    // is shown for the single cycle after the last handshake.
    int              cyc = 0;
    bit              m_on = 0;
    bit              m_act = 0;
    int              m_sel = 0;
    logic [WIDTH-1:0] m_data = '0;
    bit              m_valid = 0;
    bit              m_done = 0;
    int              load_at = -1;
    int              done_at = -1;

    always @(posedge Clock) begin
        cyc++;
        if (Resetn) begin
            m_on = 1; m_act = 0; m_sel = 0; m_data = '0; m_valid = 0;
            load_at = -1; done_at = -1;
        end else if (m_on) begin
            if (m_act && m_valid && bus.Ready) begin
                m_valid = 0;
                if (m_sel == NREGS - 1) done_at = cyc;
                else begin
                    m_sel++;
                    load_at = cyc + 1;
                end
            end else if (m_act && cyc == load_at) begin
                m_data  = bus.Regs[m_sel*WIDTH +: WIDTH];
                m_valid = 1;
            end else if (m_act && cyc == done_at + 1) begin
                m_act = 0;
            end else if (!m_act && bus.Start) begin
                m_act   = 1;
                m_sel   = 0;
                load_at = cyc + 1;
            end
        end
        m_done = m_act && (done_at == cyc);
    end

    // Compare every cycle once the model has seen a reset.
    always @(negedge Clock) begin
        if (m_on) begin
            chk("sel",   32'(bus.Sel),   32'(m_sel));
            chk("data",  32'(bus.Data),  32'(m_data));
            chk("valid", 32'(bus.Valid), 32'(m_valid));
            chk("busy",  32'(bus.Busy),  32'(m_act));
            chk("done",  32'(bus.Done),  32'(m_done));
`ifdef READBACK_PARITY_EN
            chk("parity", 32'(bus.Parity), 32'(^m_data));
`endif
            if (bus.Valid && bus.Ready) hs_cnt++;
            if (bus.Done) done_cnt++;
        end
    end

    task automatic step();
        @(posedge Clock);
        #2;
    endtask

    task automatic wait_valid_sel(input int s);
        int n = 0;
        bit found = 0;
        while (n < 100) begin
            if (bus.Valid && bus.Sel == 3'(s)) begin
                found = 1;
                break;
            end
            step();
            n++;
        end
        chk("wait_valid_sel", 32'(found), 32'd1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!bus.Done && n < 200) begin
            step();
            n++;
        end
        chk("wait_done", 32'(bus.Done), 32'd1);
    endtask

    int n;
    int d0, h0, ridx;
    logic [WIDTH-1:0] got_data[$];
    logic [2:0]       got_sel[$];

    initial begin
        Resetn    = 1'b1;
        bus.Start = 1'b0;
        bus.Ready = 1'b0;
        bus.Regs  = {NREGS{16'h0001}};
        step();
        Resetn = 1'b0;

        // Reset state
        chk("rst_valid", 32'(bus.Valid), 32'd0);
        chk("rst_busy",  32'(bus.Busy),  32'd0);
        chk("rst_sel",   32'(bus.Sel),   32'd0);
        chk("rst_data",  32'(bus.Data),  32'd0);
        chk("rst_done",  32'(bus.Done),  32'd0);

        // Scenario 1: full dump with Ready high
        bus.Start = 1'b1;
        bus.Ready = 1'b1;
        n = 0;
        while (n < 100) begin
            step();
            n++;
            bus.Start = 1'b0;
            if (bus.Valid && bus.Ready) begin
                got_data.push_back(bus.Data);
                got_sel.push_back(bus.Sel);
            end
            if (bus.Done) break;
        end
        chk("s1_done_edge", 32'(n), 32'd17);
        chk("s1_words", 32'(got_data.size()), 32'd8);
        foreach (got_data[i]) begin
            chk("s1_word_data", 32'(got_data[i]), 32'h0001);
            chk("s1_word_sel",  32'(got_sel[i]),  32'(i));
        end
        step();
        chk("s1_idle_after", 32'(bus.Busy), 32'd0);

        // Scenario 2: stall on Sel=3
        for (int i = 0; i < NREGS; i++) bus.Regs[i*WIDTH +: WIDTH] = 16'h1110 + 16'(i);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_valid_sel(3);
        bus.Ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("s2_hold_valid", 32'(bus.Valid), 32'd1);
            chk("s2_hold_data",  32'(bus.Data),  32'h1113);
            chk("s2_hold_sel",   32'(bus.Sel),   32'd3);
        end
        bus.Ready = 1'b1;
        step();
        chk("s2_accept_valid", 32'(bus.Valid), 32'd0);
        chk("s2_accept_sel",   32'(bus.Sel),   32'd4);
        wait_done();
        step();

        // Scenario 3: snapshot survives a register change
        bus.Regs[2*WIDTH +: WIDTH] = 16'hAAAA;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_valid_sel(2);
        bus.Ready = 1'b0;
        bus.Regs[2*WIDTH +: WIDTH] = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("s3_snapshot", 32'(bus.Data), 32'hAAAA);
        end
        bus.Ready = 1'b1;
        wait_done();
        step();

        // Scenario 4: Start during a dump is ignored
        step();
        h0 = hs_cnt;
        d0 = done_cnt;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_valid_sel(4);
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_done();
        step(); step(); step();
        chk("s4_words", 32'(hs_cnt - h0), 32'd8);
        chk("s4_dones", 32'(done_cnt - d0), 32'd1);
        chk("s4_idle",  32'(bus.Busy), 32'd0);

        // Scenario 5: reset mid-dump
        bus.Regs[0 +: WIDTH] = 16'hBEEF;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_valid_sel(5);
        bus.Ready = 1'b0;
        Resetn = 1'b1;
        step();
        Resetn = 1'b0;
        chk("s5_valid", 32'(bus.Valid), 32'd0);
        chk("s5_busy",  32'(bus.Busy),  32'd0);
        chk("s5_sel",   32'(bus.Sel),   32'd0);
        chk("s5_data",  32'(bus.Data),  32'd0);
        chk("s5_done",  32'(bus.Done),  32'd0);
        d0 = done_cnt;
        step(); step(); step(); step();
        chk("s5_no_done", 32'(done_cnt - d0), 32'd0);
        bus.Ready = 1'b1;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_valid_sel(0);
        chk("s5_restart_r0", 32'(bus.Data), 32'hBEEF);
        wait_done();
        step();

`ifdef READBACK_PARITY_EN
        // Scenario 6: parity of captured words
        bus.Regs[0 +: WIDTH]     = 16'h0007;
        bus.Regs[WIDTH +: WIDTH] = 16'h0003;
        bus.Ready = 1'b0;
        bus.Start = 1'b1;
        step();
        bus.Start = 1'b0;
        wait_valid_sel(0);
        chk("s6_parity_r0", 32'(bus.Parity), 32'd1);
        bus.Ready = 1'b1;
        step();
        bus.Ready = 1'b0;
        wait_valid_sel(1);
        chk("s6_parity_r1", 32'(bus.Parity), 32'd0);
        bus.Ready = 1'b1;
        wait_done();
        step();
`endif

        // Randomized traffic: random Ready, bank updates, Start pulses/holds, rare resets
        for (int i = 0; i < 1500; i++) begin
            bus.Ready = ($urandom_range(3) != 0);
            if ($urandom_range(9) == 0) begin
                ridx = int'($urandom_range(NREGS - 1));
                bus.Regs[ridx*WIDTH +: WIDTH] = 16'($urandom);
            end
            bus.Start = (i >= 600 && i < 700) ? 1'b1 : ($urandom_range(15) == 0);
            Resetn = ($urandom_range(499) == 0);
            step();
        end
        Resetn    = 1'b0;
        bus.Start = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
